fpu_share_arbiter: RTL and testbench

Shares one `fpnew_wrapper` instance between `NB_CORES` requesters (cores or APU ports) in the FPU interconnect. Arbitration is round-robin. The FPU tag carries the requester index. Results return to the issuing requester through a one-entry response register per requester, held until that requester accepts it. Each requester may have at most one operation in flight, which guarantees the FPU (`out_ready` tied high) can never overrun a response register.

---
 rtl/fpu_share_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_fpu_share_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_share_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_share_arbiter
//
// Lets NB_CORES requesters share a single fpnew_wrapper. The arbiter picks
// requesters round-robin, tags each issued operation with the requester
// index, and routes every FPU result back to the requester that issued it.
// Each requester has a one-entry response register that holds the result
// until the requester accepts it.
//
// Each requester may have only one operation in flight. Its response
// register is therefore always free when its result arrives, so the FPU can
// run with out_ready tied high.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   core_req_i        per-requester request valid
//   core_gnt_o        per-requester grant (request accepted this cycle)
//   core_operands_i   per-requester operands, NB_ARGS x DATA_WIDTH each,
//                     argument 0 in the low bits
//   core_op_i         per-requester opcode {vec_op, op_mod, op}
//   core_flags_i      per-requester {int_fmt, src_fmt, dst_fmt, rnd_mode}
//   core_rvalid_o     per-requester result valid, held until accepted
//   core_rready_i     per-requester result accept
//   core_rdata_o      per-requester result
//   core_rflags_o     per-requester status flags
//   fpu_req_o .. fpu_flags_o   request channel to the shared FPU
//   fpu_rvalid_i .. fpu_rID_i  response channel from the shared FPU
//   err_o             sticky protocol error; set on an unexpected response
// -----------------------------------------------------------------------------
module fpu_share_arbiter #(
  parameter int unsigned NB_CORES        = 4,
  parameter int unsigned ID_WIDTH        = 9,
  parameter int unsigned NB_ARGS         = 3,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned OPCODE_WIDTH    = 6,
  parameter int unsigned FLAGS_IN_WIDTH  = 15,
  parameter int unsigned FLAGS_OUT_WIDTH = 5
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  // requester side
  input  logic [NB_CORES-1:0]                    core_req_i,
  output logic [NB_CORES-1:0]                    core_gnt_o,
  input  logic [NB_CORES*NB_ARGS*DATA_WIDTH-1:0] core_operands_i,
  input  logic [NB_CORES*OPCODE_WIDTH-1:0]       core_op_i,
  input  logic [NB_CORES*FLAGS_IN_WIDTH-1:0]     core_flags_i,
  output logic [NB_CORES-1:0]                    core_rvalid_o,
  input  logic [NB_CORES-1:0]                    core_rready_i,
  output logic [NB_CORES*DATA_WIDTH-1:0]         core_rdata_o,
  output logic [NB_CORES*FLAGS_OUT_WIDTH-1:0]    core_rflags_o,
  // FPU request channel
  output logic                                   fpu_req_o,
  input  logic                                   fpu_gnt_i,
  output logic [ID_WIDTH-1:0]                    fpu_ID_o,
  output logic [NB_ARGS*DATA_WIDTH-1:0]          fpu_operands_o,
  output logic [OPCODE_WIDTH-1:0]                fpu_op_o,
  output logic [FLAGS_IN_WIDTH-1:0]              fpu_flags_o,
  // FPU response channel
  input  logic                                   fpu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                  fpu_rdata_i,
  input  logic [FLAGS_OUT_WIDTH-1:0]             fpu_rflags_i,
  input  logic [ID_WIDTH-1:0]                    fpu_rID_i,
  // status
  output logic                                   err_o
);

  localparam int unsigned PTR_W = $clog2(NB_CORES);
  localparam int unsigned OPS_W = NB_ARGS * DATA_WIDTH;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NB_CORES-1:0] pending_q, pending_d;
  logic [NB_CORES-1:0] rvalid_q, rvalid_d;
  logic                err_q, err_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [NB_CORES-1:0] elig;
  logic                any_elig;
  logic [PTR_W-1:0]    win_idx;
  logic                issue;

  // Scan from rr_ptr upward and wrap. The first eligible index wins.
  // Eligibility uses only the registered pending bits, so a requester released
  // this cycle cannot win until the next cycle.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] cand;
    idx      = 0;
    cand     = '0;
    any_elig = 1'b0;
    win_idx  = '0;
    for (int off = 0; off < int'(NB_CORES); off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= int'(NB_CORES)) begin
        idx = idx - int'(NB_CORES);
      end
      cand = idx[PTR_W-1:0];
      if (!any_elig && elig[cand]) begin
        any_elig = 1'b1;
        win_idx  = cand;
      end
    end
  end

  assign issue = any_elig & fpu_gnt_i;

  // The request channel depends only on the requests and state, never on
  // fpu_gnt_i. The FPU is free to make its grant depend on fpu_req_o.
  always_comb begin
    fpu_req_o      = any_elig;
    fpu_ID_o       = '0;
    fpu_operands_o = '0;
    fpu_op_o       = '0;
    fpu_flags_o    = '0;
    core_gnt_o     = '0;
    if (any_elig) begin
      fpu_ID_o            = ID_WIDTH'(win_idx);
      fpu_operands_o      = core_operands_i[win_idx*OPS_W +: OPS_W];
      fpu_op_o            = core_op_i[win_idx*OPCODE_WIDTH +: OPCODE_WIDTH];
      fpu_flags_o         = core_flags_i[win_idx*FLAGS_IN_WIDTH +: FLAGS_IN_WIDTH];
      core_gnt_o[win_idx] = fpu_gnt_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Response decode
  // ---------------------------------------------------------------------------
  logic             rid_in_range;
  logic [PTR_W-1:0] rid_idx;
  logic             rsp_ok;
  logic             rsp_err;

  // Widen by one bit so the range check stays correct when NB_CORES is an
  // exact power of two that fills ID_WIDTH.
  assign rid_in_range = ({1'b0, fpu_rID_i} < (ID_WIDTH+1)'(NB_CORES));
  assign rid_idx      = fpu_rID_i[PTR_W-1:0];

  // A response is accepted only if its slot expects one: the requester has
  // an operation in flight and its response register is empty. Any other
  // response is dropped and flagged.
  assign rsp_ok  = fpu_rvalid_i & rid_in_range & pending_q[rid_idx] & ~rvalid_q[rid_idx];
  assign rsp_err = fpu_rvalid_i & ~rsp_ok;

  // ---------------------------------------------------------------------------
  // Per-requester response registers
  // ---------------------------------------------------------------------------
  logic [NB_CORES-1:0] cap_vec;
  logic [NB_CORES-1:0] rel_vec;

  for (genvar gi = 0; gi < int'(NB_CORES); gi++) begin : g_core
    logic [DATA_WIDTH-1:0]      rdata_q;
    logic [FLAGS_OUT_WIDTH-1:0] rflags_q;

    assign elig[gi]    = core_req_i[gi] & ~pending_q[gi];
    assign cap_vec[gi] = rsp_ok & (rid_idx == PTR_W'(gi));
    assign rel_vec[gi] = rvalid_q[gi] & core_rready_i[gi];

    // Data is loaded only on capture. It stays stable while rvalid is high.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q  <= '0;
        rflags_q <= '0;
      end else if (cap_vec[gi]) begin
        rdata_q  <= fpu_rdata_i;
        rflags_q <= fpu_rflags_i;
      end
    end

    assign core_rdata_o[gi*DATA_WIDTH +: DATA_WIDTH]            = rdata_q;
    assign core_rflags_o[gi*FLAGS_OUT_WIDTH +: FLAGS_OUT_WIDTH] = rflags_q;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // Issue, capture and release never target the same bit in one cycle:
  // issue needs pending=0, release needs rvalid=1 (so pending=1), and capture
  // needs rvalid=0. Their update order therefore does not matter.
  always_comb begin
    pending_d = pending_q;
    rvalid_d  = rvalid_q;
    rr_ptr_d  = rr_ptr_q;
    err_d     = err_q | rsp_err;

    for (int i = 0; i < int'(NB_CORES); i++) begin
      if (rel_vec[i]) begin
        pending_d[i] = 1'b0;
        rvalid_d[i]  = 1'b0;
      end
      if (cap_vec[i]) begin
        rvalid_d[i] = 1'b1;
      end
    end

    if (issue) begin
      pending_d[win_idx] = 1'b1;
      rr_ptr_d = (win_idx == PTR_W'(NB_CORES - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      pending_q <= '0;
      rvalid_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

  assign core_rvalid_o = rvalid_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpu_share_arbiter
//
// Directed bench for fpu_share_arbiter with default parameters (4 requesters).
// Each task drives one scenario and checks hand-computed expectations inline.
// A small echo model plays the FPU where needed. It returns the tag issued
// in the previous cycle with fixed data 0xC0000000 | tag.
// -----------------------------------------------------------------------------
module tb_fpu_share_arbiter;

  localparam int NB  = 4;
  localparam int IDW = 9;
  localparam int NA  = 3;
  localparam int DW  = 32;
  localparam int OPW = 6;
  localparam int FIW = 15;
  localparam int FOW = 5;

  logic                  clk;
  logic                  rst_n;
  logic [NB-1:0]         core_req_i;
  logic [NB-1:0]         core_gnt_o;
  logic [NB*NA*DW-1:0]   core_operands_i;
  logic [NB*OPW-1:0]     core_op_i;
  logic [NB*FIW-1:0]     core_flags_i;
  logic [NB-1:0]         core_rvalid_o;
  logic [NB-1:0]         core_rready_i;
  logic [NB*DW-1:0]      core_rdata_o;
  logic [NB*FOW-1:0]     core_rflags_o;
  logic                  fpu_req_o;
  logic                  fpu_gnt_i;
  logic [IDW-1:0]        fpu_ID_o;
  logic [NA*DW-1:0]      fpu_operands_o;
  logic [OPW-1:0]        fpu_op_o;
  logic [FIW-1:0]        fpu_flags_o;
  logic                  fpu_rvalid_i;
  logic [DW-1:0]         fpu_rdata_i;
  logic [FOW-1:0]        fpu_rflags_i;
  logic [IDW-1:0]        fpu_rID_i;
  logic                  err_o;

  int                    n_cmp;
  int                    n_bad;
  logic                  prev_issue;
  logic [IDW-1:0]        prev_id;

  fpu_share_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .core_req_i      (core_req_i),
    .core_gnt_o      (core_gnt_o),
    .core_operands_i (core_operands_i),
    .core_op_i       (core_op_i),
    .core_flags_i    (core_flags_i),
    .core_rvalid_o   (core_rvalid_o),
    .core_rready_i   (core_rready_i),
    .core_rdata_o    (core_rdata_o),
    .core_rflags_o   (core_rflags_o),
    .fpu_req_o       (fpu_req_o),
    .fpu_gnt_i       (fpu_gnt_i),
    .fpu_ID_o        (fpu_ID_o),
    .fpu_operands_o  (fpu_operands_o),
    .fpu_op_o        (fpu_op_o),
    .fpu_flags_o     (fpu_flags_o),
    .fpu_rvalid_i    (fpu_rvalid_i),
    .fpu_rdata_i     (fpu_rdata_i),
    .fpu_rflags_i    (fpu_rflags_i),
    .fpu_rID_i       (fpu_rID_i),
    .err_o           (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FPU echo model: return last cycle's issued tag.
  task automatic echo_drive();
    fpu_rvalid_i = prev_issue;
    fpu_rID_i    = prev_id;
    fpu_rdata_i  = 32'hC000_0000 | 32'(prev_id);
    fpu_rflags_i = 5'h00;
  endtask

  // Stop requesting, accept everything and let in-flight operations finish.
  task automatic drain(input int n);
    core_req_i    = '0;
    core_rready_i = '1;
    for (int i = 0; i < n; i++) begin
      echo_drive();
      tick();
      prev_issue = 1'b0;
    end
    fpu_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (core_gnt_o !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", core_gnt_o); end
    n_cmp++; if (fpu_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", fpu_req_o); end
    n_cmp++; if (core_rvalid_o !== 4'b0000) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0000", core_rvalid_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_o); end
    n_cmp++; if (core_rdata_o !== '0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", core_rdata_o); end
    n_cmp++; if (fpu_operands_o !== '0 || fpu_ID_o !== '0) begin n_bad++; $display("FAIL reset_fpu_chan: ops %h id %h want 0", fpu_operands_o, fpu_ID_o); end
    tick();
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_round_robin();
    logic [NB-1:0] outstanding;
    int            exp_w;
    outstanding   = '0;
    core_req_i    = 4'b1111;
    fpu_gnt_i     = 1'b1;
    core_rready_i = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      echo_drive();
      #1;
      exp_w = c % 4;
      n_cmp++; if (core_gnt_o !== 4'(1 << exp_w)) begin n_bad++; $display("FAIL rr_order c%0d: gnt %b want %b", c, core_gnt_o, 4'(1 << exp_w)); end
      n_cmp++; if ((core_gnt_o & outstanding) !== 4'b0000) begin n_bad++; $display("FAIL rr_double_pending c%0d: gnt %b outstanding %b want no overlap", c, core_gnt_o, outstanding); end
      outstanding = (outstanding & ~(core_rvalid_o & core_rready_i)) | core_gnt_o;
      prev_issue  = fpu_req_o & fpu_gnt_i;
      prev_id     = fpu_ID_o;
      tick();
    end
    drain(4);
    $display("test_round_robin done");
  endtask

  task automatic test_response_routing();
    core_operands_i = {12{32'hDEAD_BEEF}};
    core_op_i       = '1;
    core_flags_i    = '1;
    core_operands_i[223:192] = 32'h3F80_0000;
    core_operands_i[255:224] = 32'h4000_0000;
    core_operands_i[287:256] = 32'h0000_0000;
    core_op_i[17:12]         = 6'h05;
    core_flags_i[44:30]      = 15'h1234;
    core_req_i    = 4'b0100;
    fpu_gnt_i     = 1'b1;
    core_rready_i = 4'b1111;
    #1;
    n_cmp++; if (core_gnt_o !== 4'b0100) begin n_bad++; $display("FAIL route_gnt: got %b want 0100", core_gnt_o); end
    n_cmp++; if (fpu_ID_o !== 9'd2) begin n_bad++; $display("FAIL route_id: got %0d want 2", fpu_ID_o); end
    n_cmp++; if (fpu_operands_o !== 96'h00000000_40000000_3F800000) begin n_bad++; $display("FAIL route_ops: got %h want 00000000_40000000_3f800000", fpu_operands_o); end
    n_cmp++; if (fpu_op_o !== 6'h05 || fpu_flags_o !== 15'h1234) begin n_bad++; $display("FAIL route_opflags: op %h flags %h want 05 1234", fpu_op_o, fpu_flags_o); end
    tick();
    core_req_i   = 4'b0000;
    fpu_rvalid_i = 1'b1;
    fpu_rID_i    = 9'd2;
    fpu_rdata_i  = 32'h4040_0000;
    fpu_rflags_i = 5'h01;
    #1;
    n_cmp++; if (core_rvalid_o !== 4'b0000) begin n_bad++; $display("FAIL route_early: rvalid %b want 0000", core_rvalid_o); end
    tick();
    fpu_rvalid_i = 1'b0;
    n_cmp++; if (core_rvalid_o !== 4'b0100) begin n_bad++; $display("FAIL route_rvalid: got %b want 0100", core_rvalid_o); end
    n_cmp++; if (core_rdata_o[95:64] !== 32'h4040_0000) begin n_bad++; $display("FAIL route_rdata: got %h want 40400000", core_rdata_o[95:64]); end
    n_cmp++; if (core_rflags_o[14:10] !== 5'h01) begin n_bad++; $display("FAIL route_rflags: got %h want 01", core_rflags_o[14:10]); end
    tick();
    n_cmp++; if (core_rvalid_o !== 4'b0000) begin n_bad++; $display("FAIL route_release: rvalid %b want 0000", core_rvalid_o); end
    prev_issue = 1'b0;
    $display("test_response_routing done");
  endtask

  task automatic test_backpressure();
    int exp_list [5] = '{2, 3, 0, 2, 3};
    core_req_i    = 4'b0010;
    fpu_gnt_i     = 1'b1;
    core_rready_i = 4'b1101;
    #1;
    n_cmp++; if (core_gnt_o !== 4'b0010) begin n_bad++; $display("FAIL bp_issue: gnt %b want 0010", core_gnt_o); end
    tick();
    core_req_i   = 4'b0000;
    fpu_rvalid_i = 1'b1;
    fpu_rID_i    = 9'd1;
    fpu_rdata_i  = 32'h1234_5678;
    fpu_rflags_i = 5'h0A;
    tick();
    fpu_rvalid_i = 1'b0;
    prev_issue   = 1'b0;
    core_req_i   = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      echo_drive();
      #1;
      n_cmp++; if (core_gnt_o !== 4'(1 << exp_list[c])) begin n_bad++; $display("FAIL bp_gnt c%0d: got %b want %b", c, core_gnt_o, 4'(1 << exp_list[c])); end
      n_cmp++; if (core_rvalid_o[1] !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid c%0d: got %b want 1", c, core_rvalid_o[1]); end
      n_cmp++; if (core_rdata_o[63:32] !== 32'h1234_5678 || core_rflags_o[9:5] !== 5'h0A) begin n_bad++; $display("FAIL bp_hold_data c%0d: data %h flags %h want 12345678 0a", c, core_rdata_o[63:32], core_rflags_o[9:5]); end
      prev_issue = fpu_req_o & fpu_gnt_i;
      prev_id    = fpu_ID_o;
      tick();
    end
    drain(4);
    n_cmp++; if (core_rvalid_o !== 4'b0000) begin n_bad++; $display("FAIL bp_drained: rvalid %b want 0000", core_rvalid_o); end
    $display("test_backpressure done");
  endtask

  task automatic test_fpu_stall();
    // Steer rr_ptr to 3 by issuing core 2 alone.
    core_req_i = 4'b0100;
    fpu_gnt_i  = 1'b1;
    #1;
    n_cmp++; if (core_gnt_o !== 4'b0100) begin n_bad++; $display("FAIL stall_setup: gnt %b want 0100", core_gnt_o); end
    prev_issue = fpu_req_o & fpu_gnt_i;
    prev_id    = fpu_ID_o;
    tick();
    drain(4);
    core_req_i = 4'b1001;
    fpu_gnt_i  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (core_gnt_o !== 4'b0000) begin n_bad++; $display("FAIL stall_gnt c%0d: got %b want 0000", c, core_gnt_o); end
      n_cmp++; if (fpu_req_o !== 1'b1 || fpu_ID_o !== 9'd3) begin n_bad++; $display("FAIL stall_req c%0d: req %b id %0d want 1 3", c, fpu_req_o, fpu_ID_o); end
      tick();
    end
    fpu_gnt_i = 1'b1;
    #1;
    n_cmp++; if (core_gnt_o !== 4'b1000) begin n_bad++; $display("FAIL stall_first: gnt %b want 1000", core_gnt_o); end
    prev_issue = fpu_req_o & fpu_gnt_i;
    prev_id    = fpu_ID_o;
    tick();
    echo_drive();
    #1;
    n_cmp++; if (core_gnt_o !== 4'b0001) begin n_bad++; $display("FAIL stall_second: gnt %b want 0001", core_gnt_o); end
    prev_issue = fpu_req_o & fpu_gnt_i;
    prev_id    = fpu_ID_o;
    tick();
    drain(4);
    $display("test_fpu_stall done");
  endtask

  task automatic test_error_and_simul();
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_clean: got %b want 0", err_o); end
    core_req_i    = 4'b0000;
    fpu_rvalid_i  = 1'b1;
    fpu_rID_i     = 9'd2;
    fpu_rdata_i   = 32'h5555_5555;
    fpu_rflags_i  = 5'h1F;
    tick();
    fpu_rvalid_i  = 1'b0;
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", err_o); end
    n_cmp++; if (core_rvalid_o !== 4'b0000) begin n_bad++; $display("FAIL err_no_rvalid: got %b want 0000", core_rvalid_o); end
    // rr_ptr is 1 here: core 1 then core 0.
    core_req_i    = 4'b0011;
    core_rready_i = 4'b0000;
    fpu_gnt_i     = 1'b1;
    #1;
    n_cmp++; if (core_gnt_o !== 4'b0010) begin n_bad++; $display("FAIL sim_gnt1: got %b want 0010", core_gnt_o); end
    tick();
    n_cmp++; if (core_gnt_o !== 4'b0001) begin n_bad++; $display("FAIL sim_gnt0: got %b want 0001", core_gnt_o); end
    tick();
    core_req_i   = 4'b0000;
    fpu_rvalid_i = 1'b1;
    fpu_rID_i    = 9'd0;
    fpu_rdata_i  = 32'hAAAA_0000;
    fpu_rflags_i = 5'h02;
    tick();
    // Release core 0 while capturing core 1. Core 0 requests again but must wait a cycle.
    fpu_rID_i     = 9'd1;
    fpu_rdata_i   = 32'hBBBB_1111;
    fpu_rflags_i  = 5'h04;
    core_rready_i = 4'b0001;
    core_req_i    = 4'b0001;
    #1;
    n_cmp++; if (core_rvalid_o !== 4'b0001) begin n_bad++; $display("FAIL sim_pre: rvalid %b want 0001", core_rvalid_o); end
    n_cmp++; if (core_gnt_o !== 4'b0000 || fpu_req_o !== 1'b0) begin n_bad++; $display("FAIL sim_not_yet_elig: gnt %b req %b want 0000 0", core_gnt_o, fpu_req_o); end
    tick();
    fpu_rvalid_i = 1'b0;
    n_cmp++; if (core_rvalid_o !== 4'b0010) begin n_bad++; $display("FAIL sim_both: rvalid %b want 0010", core_rvalid_o); end
    n_cmp++; if (core_rdata_o[63:32] !== 32'hBBBB_1111) begin n_bad++; $display("FAIL sim_rdata1: got %h want bbbb1111", core_rdata_o[63:32]); end
    n_cmp++; if (core_gnt_o !== 4'b0001) begin n_bad++; $display("FAIL sim_reelig: gnt %b want 0001", core_gnt_o); end
    prev_issue = fpu_req_o & fpu_gnt_i;
    prev_id    = fpu_ID_o;
    tick();
    drain(4);
    $display("test_error_and_simul done");
  endtask

  task automatic test_reset_midflight();
    // rr_ptr is 1 here: grants go 1, 2, 0.
    core_req_i    = 4'b0111;
    core_rready_i = 4'b0000;
    fpu_gnt_i     = 1'b1;
    #1;
    n_cmp++; if (core_gnt_o !== 4'b0010) begin n_bad++; $display("FAIL mid_gnt_a: got %b want 0010", core_gnt_o); end
    tick();
    fpu_rvalid_i = 1'b1;
    fpu_rID_i    = 9'd1;
    fpu_rdata_i  = 32'hDEAD_0001;
    fpu_rflags_i = 5'h03;
    #1;
    n_cmp++; if (core_gnt_o !== 4'b0100) begin n_bad++; $display("FAIL mid_gnt_b: got %b want 0100", core_gnt_o); end
    tick();
    fpu_rvalid_i = 1'b0;
    #1;
    n_cmp++; if (core_gnt_o !== 4'b0001) begin n_bad++; $display("FAIL mid_gnt_c: got %b want 0001", core_gnt_o); end
    n_cmp++; if (core_rvalid_o !== 4'b0010) begin n_bad++; $display("FAIL mid_rvalid: got %b want 0010", core_rvalid_o); end
    tick();
    core_req_i = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (core_rvalid_o !== 4'b0000 || err_o !== 1'b0) begin n_bad++; $display("FAIL mid_async_clear: rvalid %b err %b want 0000 0", core_rvalid_o, err_o); end
    n_cmp++; if (core_rdata_o !== '0 || core_rflags_o !== '0) begin n_bad++; $display("FAIL mid_async_data: rdata %h rflags %h want 0", core_rdata_o, core_rflags_o); end
    n_cmp++; if (core_gnt_o !== 4'b0000 || fpu_req_o !== 1'b0) begin n_bad++; $display("FAIL mid_async_req: gnt %b req %b want 0000 0", core_gnt_o, fpu_req_o); end
    tick();
    tick();
    rst_n         = 1'b1;
    core_req_i    = 4'b1111;
    core_rready_i = 4'b1111;
    #1;
    n_cmp++; if (core_gnt_o !== 4'b0001) begin n_bad++; $display("FAIL mid_first_after: gnt %b want 0001", core_gnt_o); end
    tick();
    core_req_i   = 4'b0000;
    fpu_rvalid_i = 1'b1;
    fpu_rID_i    = 9'd2;
    fpu_rdata_i  = 32'hDEAD_0002;
    tick();
    fpu_rvalid_i = 1'b0;
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL mid_late_err: got %b want 1", err_o); end
    n_cmp++; if (core_rvalid_o !== 4'b0000) begin n_bad++; $display("FAIL mid_late_drop: rvalid %b want 0000", core_rvalid_o); end
    $display("test_reset_midflight done");
  endtask

  initial begin
    n_cmp           = 0;
    n_bad           = 0;
    prev_issue      = 1'b0;
    prev_id         = '0;
    rst_n           = 1'b0;
    core_req_i      = '0;
    core_operands_i = '0;
    core_op_i       = '0;
    core_flags_i    = '0;
    core_rready_i   = '0;
    fpu_gnt_i       = 1'b0;
    fpu_rvalid_i    = 1'b0;
    fpu_rdata_i     = '0;
    fpu_rflags_i    = '0;
    fpu_rID_i       = '0;

    test_reset();
    test_round_robin();
    test_response_routing();
    test_backpressure();
    test_fpu_stall();
    test_error_and_simul();
    test_reset_midflight();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
